// File: rtl/game_round_ctrl.sv
// Round sequencing FSM: start, play, death animation, respawn, game over / win; outputs decode from state in the same cycle.
// Optional lives counting is built in when GAME_LIVES_EN is defined; otherwise lives_left stays at 0 and every death ends the game.
module game_round_ctrl #(
  parameter int DEATH_FRAMES = 60,
  parameter int LIVES        = 3
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic       start_btn,
  input  logic       player1_dead,
  input  logic       player2_dead,
  input  logic       player1_at_exit,
  input  logic       player2_at_exit,
  output logic [2:0] state_out,
  output logic       hazard_reset,
  output logic       freeze,
  output logic       blink,
  output logic [1:0] lives_left,
  output logic       round_done
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PLAYING   = 3'd1,
    DYING     = 3'd2,
    RESPAWN   = 3'd3,
    GAME_OVER = 3'd4,
    WIN       = 3'd5
  } state_e;

`ifdef GAME_LIVES_EN
  localparam bit LIVES_EN = 1'b1;
`else
  localparam bit LIVES_EN = 1'b0;
`endif

  localparam logic [7:0] DEATH_LAST = 8'(DEATH_FRAMES);
  localparam logic [1:0] LIVES_INIT = 2'(LIVES);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] lives_q, lives_d;
  logic       start_prev_q;
  logic       start_rise;

  assign start_rise = start_btn & ~start_prev_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= IDLE;
      cnt_q        <= 8'd0;
      lives_q      <= 2'd0;
      // Held high so a button pressed through reset cannot start a round.
      start_prev_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      lives_q      <= lives_d;
      start_prev_q <= start_btn;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lives_d = lives_q;
    case (state_q)
      IDLE: begin
        if (start_rise) begin
          lives_d = LIVES_EN ? LIVES_INIT : 2'd0;
          state_d = PLAYING;
        end
      end
      PLAYING: begin
        // Death outranks reaching the exits in the same cycle.
        if (player1_dead || player2_dead) begin
          state_d = DYING;
          cnt_d   = 8'd0;
        end else if (player1_at_exit && player2_at_exit) begin
          state_d = WIN;
        end
      end
      DYING: begin
        if (frame_tick) begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_d == DEATH_LAST) begin
            if (LIVES_EN && (lives_q > 2'd1)) begin
              lives_d = lives_q - 2'd1;
              state_d = RESPAWN;
            end else begin
              lives_d = 2'd0;
              state_d = GAME_OVER;
            end
          end
        end
      end
      RESPAWN: state_d = PLAYING;
      GAME_OVER, WIN: begin
        if (start_rise) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    state_out    = state_q;
    hazard_reset = (state_q == IDLE) || (state_q == RESPAWN);
    freeze       = (state_q == DYING) || (state_q == GAME_OVER) || (state_q == WIN);
    round_done   = (state_q == GAME_OVER) || (state_q == WIN);
    blink        = (state_q == DYING) & cnt_q[3];
    lives_left   = lives_q;
  end

endmodule

// File: doc/game_round_ctrl.md
GAME_ROUND_CTRL -- requirements
Module: game_round_ctrl

Interface
Parameters:
REQ-001 The block SHALL have parameter DEATH_FRAMES, default 60: the number of frame_tick pulses spent in DYING (legal range 1..255).
REQ-002 The block SHALL have parameter LIVES, default 3: the lives loaded at round start (legal range 1..3).

Ports:
REQ-003 The block SHALL have port Clk, input, 1 bit: the single clock.
REQ-004 The block SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port frame_tick, input, 1 bit: one-Clk pulse per video frame.
REQ-006 The block SHALL have port start_btn, input, 1 bit: level-sensitive start/continue button, already synchronised to Clk.
REQ-007 The block SHALL have ports player1_dead and player2_dead, inputs, 1 bit each: sticky death flags from the water hazards.
REQ-008 The block SHALL have ports player1_at_exit and player2_at_exit, inputs, 1 bit each: each player is inside its exit door.
REQ-009 The block SHALL have port state_out, output, 3 bits: current state encoding.
REQ-010 The block SHALL have port hazard_reset, output, 1 bit: drives the Reset input of the hazard controllers.
REQ-011 The block SHALL have port freeze, output, 1 bit: stops player motion.
REQ-012 The block SHALL have port blink, output, 1 bit: sprite blink enable during death.
REQ-013 The block SHALL have port lives_left, output, 2 bits: remaining lives.
REQ-014 The block SHALL have port round_done, output, 1 bit: high while the round is over.

Function
REQ-015 The FSM SHALL use these state encodings: IDLE=0, PLAYING=1, DYING=2, RESPAWN=3, GAME_OVER=4, WIN=5; encodings 6 and 7 SHALL return to IDLE on the next clock.
REQ-016 start_btn SHALL be rising-edge detected internally (start_rise = start_btn and not its previous-cycle value), so a held button causes exactly one advance.
REQ-017 In IDLE, start_rise SHALL cause these actions on the same edge:
- load lives_left with LIVES;
- move to PLAYING.
REQ-018 In PLAYING, player1_dead or player2_dead SHALL cause a move to DYING and clear the frame counter to 0.
REQ-019 In PLAYING, if neither player is dead, player1_at_exit and player2_at_exit both high SHALL cause a move to WIN.
REQ-020 When death and exit occur in the same cycle, death SHALL take priority.
REQ-021 In DYING, each frame_tick SHALL increment an 8-bit frame counter.
REQ-022 In DYING, the frame_tick that brings the counter to DEATH_FRAMES SHALL end DYING on that same edge.
REQ-023 On leaving DYING, the next state SHALL be chosen by the Configuration rules (REQ-033, REQ-034).
REQ-024 RESPAWN SHALL last exactly one Clk cycle and then move to PLAYING.
REQ-025 In GAME_OVER or WIN, start_rise SHALL move the FSM to IDLE; all other inputs SHALL be ignored.
REQ-026 hazard_reset SHALL be combinational from state: 1 in IDLE and RESPAWN, 0 otherwise; this guarantees the hazard death flags are cleared before PLAYING.
REQ-027 freeze SHALL be 1 in DYING, GAME_OVER and WIN, and 0 otherwise.
REQ-028 round_done SHALL be 1 in GAME_OVER and WIN only.
REQ-029 blink SHALL equal frame counter bit 3 while in DYING, and 0 in all other states.
REQ-030 frame_tick outside DYING SHALL have no effect.

Reset
REQ-031 While Reset is high at a Clk edge, the block SHALL force:
- state to IDLE;
- frame counter to 0;
- lives_left to 0;
- the start_btn edge register to 1, so a button held through reset does not start a round.
REQ-032 A Reset asserted in any state, including mid-DYING, SHALL take effect on the next edge with these output values: hazard_reset=1, freeze=0, blink=0, round_done=0, state_out=0.

Configuration
REQ-033 With macro GAME_LIVES_EN defined, leaving DYING SHALL behave as follows:
- if lives_left > 1: decrement lives_left and move to RESPAWN;
- otherwise: set lives_left to 0 and move to GAME_OVER.
REQ-034 With GAME_LIVES_EN undefined, leaving DYING SHALL always move to GAME_OVER, and lives_left SHALL be held at 0 constantly.

Verification
REQ-035 Scenario: Reset, then start_btn rises -> state 0->1 in one cycle, lives_left=3, hazard_reset 1->0.
REQ-036 Scenario: PLAYING, player1_dead=1 together with both at_exit=1 -> DYING (not WIN), freeze=1; blink toggles every 8 frame_ticks.
REQ-037 Scenario: GAME_LIVES_EN defined, DEATH_FRAMES=60 -> on the 60th tick go to RESPAWN for one cycle with hazard_reset=1, then PLAYING with lives_left=2; the third death leads to GAME_OVER with lives_left=0.
REQ-038 Scenario: GAME_LIVES_EN undefined -> the first death leads to GAME_OVER after 60 ticks, round_done=1, lives_left=0.
REQ-039 Scenario: WIN with start_btn held high across the transition -> remains in WIN; release then press -> IDLE, then PLAYING on the next press.
REQ-040 Scenario: Reset pulse at tick 30 of DYING -> IDLE next cycle, counter=0, freeze=0, held start_btn ignored until released and pressed again.
